// File: rtl/ecc_pkg.sv
// Shared constants and tx state encoding for the ECC nibble loader and the point transmitter.
package ecc_pkg;

  localparam int ECC_NIB   = 4;
  localparam int ECC_WIDTH = 32;
  localparam int ECC_BEATS = ECC_WIDTH / ECC_NIB;

  typedef enum logic [2:0] {
    IDLE,
    SEND_X,
    SEND_Y,
    SEND_CK,
    DONE
  } tx_state_e;

endpackage

// File: rtl/nibble_shift_reg.sv
// Coordinate register with parallel load that shifts right one nibble per enable.
// The low nibble is always the next one to go out.
module nibble_shift_reg
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH,
  parameter int NIB   = ECC_NIB
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic [NIB-1:0]   o_nibble
);

  logic [WIDTH-1:0] q;

  // A load has priority over a shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        q <= '0;
    else if (i_load)  q <= i_d;
    else if (i_shift) q <= q >> NIB;
  end

  assign o_nibble = q[NIB-1:0];

endmodule

// File: rtl/ecc_point_nibble_tx.sv
// Captures the affine result point and streams it over the 4-bit kP pin, LS nibble first, x then y.
// Defining ECC_TX_CHECKSUM_EN appends an XOR checksum beat (state SEND_CK) to every frame.
module ecc_point_nibble_tx
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH,
  parameter int NIB   = ECC_NIB
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_ready,
  output logic [NIB-1:0]   o_nibble,
  output logic             o_valid,
  output logic             o_first,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BEATS = WIDTH / NIB;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_int, accept, capture, shift_x, shift_y;
  logic [NIB-1:0] x_nib, y_nib;

  // A new point is only taken when no frame is in flight.
  assign capture   = i_load && (state_q == IDLE || state_q == DONE);
  assign valid_int = (state_q == SEND_X) || (state_q == SEND_Y) || (state_q == SEND_CK);
  assign accept    = valid_int && i_ready;
  assign shift_x   = accept && (state_q == SEND_X);
  assign shift_y   = accept && (state_q == SEND_Y);

  nibble_shift_reg #(.WIDTH(WIDTH), .NIB(NIB)) u_x_sr (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(capture), .i_shift(shift_x),
    .i_d(i_x), .o_nibble(x_nib)
  );

  nibble_shift_reg #(.WIDTH(WIDTH), .NIB(NIB)) u_y_sr (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(capture), .i_shift(shift_y),
    .i_d(i_y), .o_nibble(y_nib)
  );

`ifdef ECC_TX_CHECKSUM_EN
  logic [NIB-1:0] ck_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   ck_q <= '0;
    else if (capture)            ck_q <= '0;
    else if (shift_x || shift_y) ck_q <= ck_q ^ o_nibble;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    o_valid  = valid_int;
    o_busy   = valid_int;
    o_nibble = '0;
    o_first  = 1'b0;
    o_last   = 1'b0;
    o_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          state_d = SEND_X;
          cnt_d   = '0;
        end
      end
      SEND_X: begin
        o_nibble = x_nib;
        o_first  = (cnt_q == '0);
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = SEND_Y;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SEND_Y: begin
        o_nibble = y_nib;
`ifndef ECC_TX_CHECKSUM_EN
        o_last   = (cnt_q == LAST_CNT);
`endif
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef ECC_TX_CHECKSUM_EN
            state_d = SEND_CK;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef ECC_TX_CHECKSUM_EN
      SEND_CK: begin
        o_nibble = ck_q;
        o_last   = 1'b1;
        if (accept) state_d = DONE;
      end
`endif
      DONE: begin
        o_done = 1'b1;
        if (i_load) begin
          state_d = SEND_X;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ecc_point_nibble_tx.sv
// Scoreboard bench for ecc_point_nibble_tx: expected beats are queued at load time and popped on accept.
module tb_ecc_point_nibble_tx;
  import ecc_pkg::*;

  localparam int WIDTH = 32;
  localparam int NIB   = 4;
  localparam int BEATS = WIDTH / NIB;
`ifdef ECC_TX_CHECKSUM_EN
  localparam int TOTAL = 2 * BEATS + 1;
`else
  localparam int TOTAL = 2 * BEATS;
`endif

  logic             i_clk, i_rst, i_load, i_ready;
  logic [WIDTH-1:0] i_x, i_y;
  logic [NIB-1:0]   o_nibble;
  logic             o_valid, o_first, o_last, o_busy, o_done;

  typedef struct packed {
    logic           first;
    logic           last;
    logic [NIB-1:0] nib;
  } beat_t;

  beat_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  ecc_point_nibble_tx #(.WIDTH(WIDTH), .NIB(NIB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_x(i_x), .i_y(i_y),
    .i_ready(i_ready), .o_nibble(o_nibble), .o_valid(o_valid), .o_first(o_first),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference frame: x nibbles LS first, then y, then optional XOR checksum beat.
  task automatic push_frame(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    beat_t b;
    logic [NIB-1:0] ck;
    ck = '0;
    for (int i = 0; i < BEATS; i++) begin
      b.first = (i == 0);
      b.last  = 1'b0;
      b.nib   = x[i*NIB +: NIB];
      ck ^= b.nib;
      sb.push_back(b);
    end
    for (int i = 0; i < BEATS; i++) begin
      b.first = 1'b0;
      b.last  = (i == BEATS - 1) && (TOTAL == 2 * BEATS);
      b.nib   = y[i*NIB +: NIB];
      ck ^= b.nib;
      sb.push_back(b);
    end
    if (TOTAL != 2 * BEATS) begin
      b.first = 1'b0;
      b.last  = 1'b1;
      b.nib   = ck;
      sb.push_back(b);
    end
  endtask

  task automatic start_load(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge i_clk);
    i_load  = 1'b1;
    i_x     = x;
    i_y     = y;
    i_ready = 1'b1;
    push_frame(x, y);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_load = 1'b0; i_ready = 1'b0; i_x = '0; i_y = '0;
    repeat (2) @(negedge i_clk);
    #1;
    n_cmp++;
    if ({o_nibble, o_valid, o_first, o_last, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b, expected 0",
               {o_nibble, o_valid, o_first, o_last, o_busy, o_done});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_nibble, o_valid, o_first, o_last, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_outputs: got %b, expected 0",
               {o_nibble, o_valid, o_first, o_last, o_busy, o_done});
    end
  endtask

  task automatic test_basic_frame();
    beat_t exp, got;
    int cyc = 0;
    bit done = 0;
    start_load(32'h89ABCDEF, 32'h01234567);
    while (!done && cyc < 100) begin
      @(negedge i_clk);
      i_load = 1'b0; i_ready = 1'b1;
      #1;
      got = {o_first, o_last, o_nibble};
      n_cmp++;
      if (o_done) begin
        done = 1;
        if (cyc !== TOTAL || sb.size() != 0) begin
          n_fail++;
          $display("[TB] FAIL basic_done: cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), TOTAL);
        end
      end else if (!o_valid || !o_busy || sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL basic_gap: cycle %0d valid %b busy %b queued %0d", cyc, o_valid, o_busy, sb.size());
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("[TB] FAIL basic_beat: cycle %0d got %h, expected %h", cyc, got, exp);
        end
      end
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL basic_timeout: no o_done after %0d cycles, expected one", cyc);
    end
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (o_done !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_pulse: done %b valid %b one cycle later, expected 0 0", o_done, o_valid);
    end
  endtask

  task automatic test_stall();
    beat_t exp, got;
    int cyc = 0;
    int stalls = 0;
    bit done = 0;
    start_load(32'h89ABCDEF, 32'h01234567);
    while (!done && cyc < 100) begin
      @(negedge i_clk);
      i_load  = 1'b0;
      i_ready = 1'b1;
      if ((TOTAL - sb.size()) == 5 && stalls < 3) begin
        i_ready = 1'b0;
        stalls++;
      end
      #1;
      got = {o_first, o_last, o_nibble};
      n_cmp++;
      if (o_done) begin
        done = 1;
        if (cyc !== TOTAL + 3 || sb.size() != 0) begin
          n_fail++;
          $display("[TB] FAIL stall_done: cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), TOTAL + 3);
        end
      end else if (!o_valid || sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL stall_gap: cycle %0d valid %b queued %0d", cyc, o_valid, sb.size());
      end else begin
        exp = i_ready ? sb.pop_front() : sb[0];
        if (got !== exp) begin
          n_fail++;
          $display("[TB] FAIL stall_beat: cycle %0d ready %b got %h, expected %h", cyc, i_ready, got, exp);
        end
      end
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL stall_timeout: no o_done after %0d cycles, expected one", cyc);
    end
  endtask

  task automatic test_load_ignored();
    beat_t exp, got;
    int cyc = 0;
    bit done = 0;
    start_load(32'h89ABCDEF, 32'h01234567);
    while (!done && cyc < 100) begin
      @(negedge i_clk);
      i_ready = 1'b1;
      i_load  = ((TOTAL - sb.size()) == 9);
      if (i_load) begin
        i_x = '0;
        i_y = '0;
      end
      #1;
      got = {o_first, o_last, o_nibble};
      n_cmp++;
      if (o_done) begin
        done = 1;
        if (cyc !== TOTAL || sb.size() != 0) begin
          n_fail++;
          $display("[TB] FAIL busyload_done: cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), TOTAL);
        end
      end else if (!o_valid || sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL busyload_gap: cycle %0d valid %b queued %0d", cyc, o_valid, sb.size());
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("[TB] FAIL busyload_beat: cycle %0d got %h, expected %h", cyc, got, exp);
        end
      end
      cyc++;
    end
    i_load = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL busyload_timeout: no o_done after %0d cycles, expected one", cyc);
    end
  endtask

  task automatic test_reset_midframe();
    beat_t exp, got;
    int cyc = 0;
    start_load(32'h89ABCDEF, 32'h01234567);
    while ((TOTAL - sb.size()) < 10 && cyc < 100) begin
      @(negedge i_clk);
      i_load = 1'b0; i_ready = 1'b1;
      #1;
      got = {o_first, o_last, o_nibble};
      n_cmp++;
      if (!o_valid || sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL midrst_gap: cycle %0d valid %b", cyc, o_valid);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("[TB] FAIL midrst_beat: cycle %0d got %h, expected %h", cyc, got, exp);
        end
      end
      cyc++;
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    sb.delete();
    n_cmp++;
    if ({o_nibble, o_valid, o_first, o_last, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: got %b, expected 0",
               {o_nibble, o_valid, o_first, o_last, o_busy, o_done});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1;
      n_cmp++;
      if (o_done !== 1'b0 || o_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midrst_idle: done %b valid %b, expected 0 0", o_done, o_valid);
      end
    end
    start_load(32'h89ABCDEF, 32'h01234567);
    @(negedge i_clk);
    i_load = 1'b0;
    #1;
    exp = sb.pop_front();
    got = {o_first, o_last, o_nibble};
    n_cmp++;
    if (!o_valid || got !== exp) begin
      n_fail++;
      $display("[TB] FAIL midrst_restart: valid %b got %h, expected 1 %h", o_valid, got, exp);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    sb.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    beat_t exp, got;
    int cyc = 0;
    int frames = 0;
    start_load(32'h89ABCDEF, 32'h01234567);
    while (frames < 2 && cyc < 200) begin
      @(negedge i_clk);
      i_load = 1'b0; i_ready = 1'b1;
      #1;
      got = {o_first, o_last, o_nibble};
      n_cmp++;
      if (o_done) begin
        frames++;
        if (cyc !== frames * (TOTAL + 1) - 1 || sb.size() != 0) begin
          n_fail++;
          $display("[TB] FAIL b2b_done: frame %0d cycle %0d left %0d, expected cycle %0d left 0",
                   frames, cyc, sb.size(), frames * (TOTAL + 1) - 1);
        end
        if (frames == 1) begin
          i_load = 1'b1;
          i_x    = 32'h00000001;
          i_y    = '0;
          push_frame(32'h00000001, '0);
        end
      end else if (!o_valid || sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL b2b_gap: cycle %0d valid %b queued %0d", cyc, o_valid, sb.size());
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("[TB] FAIL b2b_beat: cycle %0d got %h, expected %h", cyc, got, exp);
        end
      end
      cyc++;
    end
    if (frames < 2) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL b2b_timeout: %0d frames done after %0d cycles, expected 2", frames, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_load_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_point_nibble_tx.md
Name: ecc_point_nibble_tx

Overview:
Output-side counterpart of the 4-bit nibble operand loader at the ECC top level. It captures the final affine result point (x, y) when the control unit reports all-done, then streams it out over the 4-bit kP pin, least-significant nibble first, x before y. Transfers use a valid/ready handshake so the pin-side consumer can stall. The block sits between Control's output_1/output_2/all_done and the top-level kP port.

Parameters:
WIDTH, 32, coordinate width in bits; must be a multiple of NIB.
NIB, 4, output nibble width in bits.
(derived) BEATS = WIDTH/NIB = 8 nibbles per coordinate.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_load  input  1  one-cycle pulse from Control all_done; captures i_x/i_y.
i_x  input  WIDTH  result x coordinate (Control output_1).
i_y  input  WIDTH  result y coordinate (Control output_2).
i_ready  input  1  consumer accepts the current nibble this cycle.
o_nibble  output  NIB  current nibble; 0 when o_valid=0.
o_valid  output  1  o_nibble is valid.
o_first  output  1  high with the first beat (x[3:0]).
o_last  output  1  high with the final beat of the frame.
o_busy  output  1  frame in progress (SEND_X/SEND_Y/SEND_CK).
o_done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (any time, including mid-frame): state=IDLE, beat counter=0, shift registers=0; all outputs 0. Partial frame discarded; no o_done.
- States: IDLE, SEND_X, SEND_Y, (SEND_CK with macro), DONE.
- IDLE: i_load=1 -> capture i_x into xs, i_y into ys, cnt=0, go SEND_X. Load at edge t gives o_valid=1 with x[3:0] in cycle t+1 (1-cycle latency).
- Beat accepted when o_valid & i_ready. On accept: shift the active register right by NIB, cnt+=1. o_nibble = active register[NIB-1:0].
- i_ready=0: hold o_nibble, o_valid, o_first, o_last stable; no state change.
- SEND_X: accept with cnt=BEATS-1 -> cnt=0, go SEND_Y.
- SEND_Y: accept with cnt=BEATS-1 -> DONE (no macro) or SEND_CK (with macro).
- DONE: o_done=1 for exactly this cycle; o_valid=0; next state IDLE, or SEND_X if i_load=1 in the same cycle (new capture, back-to-back frames).
- i_load while busy: ignored; captured data is not disturbed.
- o_first = (state==SEND_X && cnt==0). o_last = final beat of frame (SEND_Y cnt=BEATS-1 without macro; SEND_CK with macro).
- Minimum frame with i_ready tied high: 2*BEATS cycles of valid, o_done on the next cycle (16 + 1 at defaults).
- Counter width = clog2(BEATS); never exceeds BEATS-1.

Optional Feature:
ECC_TX_CHECKSUM_EN: when defined, the frame appends one extra beat in state SEND_CK carrying the XOR of all 2*BEATS transmitted nibbles, accumulated on each accept. o_last moves to this beat; the frame is 17 beats at defaults. The accumulator clears on capture and on reset. When undefined, SEND_CK and the accumulator do not exist, and the frame is 16 beats.

Decomposition:
- Shared package ecc_pkg: NIB width, default WIDTH, derived BEATS; tx state enum (IDLE, SEND_X, SEND_Y, SEND_CK, DONE). The loader reuses the same NIB and BEATS constants, which keeps nibble order consistent.
- Sub-module nibble_shift_reg (parallel load, shift right by NIB, enable): instantiated twice, for x and y.

Test Plan:
- Reset, then i_load with x=32'h89ABCDEF, y=32'h01234567, i_ready=1 -> nibbles F,E,D,C,B,A,9,8,7,6,5,4,3,2,1,0 on consecutive cycles. o_first on F, o_last on 0, o_done pulse the next cycle.
- Same frame with i_ready low for 3 cycles during beat 5 -> nibble A held stable with o_valid=1 for 4 cycles; sequence otherwise unchanged; o_done 3 cycles later.
- i_load again at beat 9 with x=y=0 -> ignored; remaining nibbles still 6..0 from the original y.
- i_rst asserted at beat 10 -> all outputs 0 immediately, state IDLE, no o_done. A fresh load then restarts from x[3:0].
- i_load coincident with DONE, new x=32'h00000001, y=0 -> next cycle o_valid=1 with nibble 1 and o_first=1, no idle gap.
- With ECC_TX_CHECKSUM_EN: x=32'h00000001, y=0 -> 17th beat nibble 1 with o_last. x=32'h89ABCDEF, y=32'h01234567 -> checksum beat 0.
